// File: rtl/testeio_memout_pkg.sv
// Shared constants for the testeio memory-out FIFO slave: register
// addresses and the bit positions of the STATUS and CONTROL registers.
package testeio_memout_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_STATUS  = 2'd1,
        ADDR_CONTROL = 2'd2,
        ADDR_RSVD    = 2'd3
    } addr_e;

    // STATUS register fields
    localparam int unsigned FULL_BIT  = 0;
    localparam int unsigned EMPTY_BIT = 1;
    localparam int unsigned OVF_BIT   = 2;
    localparam int unsigned CNT_LSB   = 8;

    // CONTROL register fields
    localparam int unsigned EN_BIT    = 0;
    localparam int unsigned FLUSH_BIT = 1;
    localparam int unsigned IRQM_BIT  = 2;

    localparam int unsigned AV_DATA_W = 32;

    // An Avalon write strobe is only meaningful while the slave is selected.
    function automatic logic is_write(input logic cs, input logic wr_n);
        return cs && !wr_n;
    endfunction

endpackage

// File: rtl/testeio_memout_fifo_core.sv
// Synchronous FIFO used by testeio_memout_fifo. Flush has priority over
// push and pop; a push into a full FIFO is accepted only when a pop happens
// in the same cycle. The head output reads zero while the FIFO is empty.
module testeio_memout_fifo_core #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic                    i_flush,
    input  logic [DATA_W-1:0]       i_data,
    output logic [DATA_W-1:0]       o_head,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Qualify requests: flush discards both, a pop frees room for a push.
    always_comb begin
        w_do_pop  = i_pop && !o_empty && !i_flush;
        w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because the head is gated by empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/testeio_memout_fifo.sv
// Avalon-MM write-side slave: host bytes written to DATA are queued and
// presented on out_port under an out_valid/out_ack handshake. STATUS and
// CONTROL are readable with one cycle of read latency.
// Optional build macro: TESTEIO_MEMOUT_IRQ_EN adds the irq output and the
// CONTROL irq_mask bit.
module testeio_memout_fifo
    import testeio_memout_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [AV_DATA_W-1:0]  writedata,
    output logic [AV_DATA_W-1:0]  readdata,
    output logic [DATA_W-1:0]     out_port,
    output logic                  out_valid,
    input  logic                  out_ack
`ifdef TESTEIO_MEMOUT_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                  w_wr;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_flush;
    logic                  w_ovf_clr;
    logic                  w_ctrl_wr;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    logic [DATA_W-1:0]     w_head;
    logic [AV_DATA_W-1:0]  w_rdata_nxt;
    logic                  w_unused;
    logic                  r_enable;
    logic                  r_overflow;
    logic [AV_DATA_W-1:0]  r_readdata;
`ifdef TESTEIO_MEMOUT_IRQ_EN
    logic                  r_irq_mask;
    logic                  r_irq;
`endif

    assign w_wr      = is_write(chipselect, write_n);
    assign w_push    = w_wr && (addr_e'(address) == ADDR_DATA);
    assign w_ovf_clr = w_wr && (addr_e'(address) == ADDR_STATUS) && writedata[OVF_BIT];
    assign w_ctrl_wr = w_wr && (addr_e'(address) == ADDR_CONTROL);
    assign w_flush   = w_ctrl_wr && writedata[FLUSH_BIT];
    assign w_pop     = out_valid && out_ack;
    assign w_unused  = ^writedata;

    // out_valid/out_port are decoded only from flops, so they change
    // together with the FIFO state on the clock edge.
    assign out_valid = r_enable && !w_empty;
    assign out_port  = w_head;
    assign readdata  = r_readdata;

    testeio_memout_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  (writedata[DATA_W-1:0]),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Control bits and the sticky overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_enable   <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_enable <= writedata[EN_BIT];
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            else if (w_ovf_clr)             r_overflow <= 1'b0;
        end
    end

    // Read mux for the register map; unmapped bits and address 3 read zero.
    always_comb begin
        w_rdata_nxt = '0;
        case (addr_e'(address))
            ADDR_DATA: begin
                w_rdata_nxt[DATA_W-1:0] = w_head;
            end
            ADDR_STATUS: begin
                w_rdata_nxt[FULL_BIT]            = w_full;
                w_rdata_nxt[EMPTY_BIT]           = w_empty;
                w_rdata_nxt[OVF_BIT]             = r_overflow;
                w_rdata_nxt[CNT_LSB +: CNT_W]    = w_count;
            end
            ADDR_CONTROL: begin
                w_rdata_nxt[EN_BIT]   = r_enable;
`ifdef TESTEIO_MEMOUT_IRQ_EN
                w_rdata_nxt[IRQM_BIT] = r_irq_mask;
`endif
            end
            default: w_rdata_nxt = '0;
        endcase
    end

    // Registered read data, refreshed every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_readdata <= '0;
        else          r_readdata <= w_rdata_nxt;
    end

`ifdef TESTEIO_MEMOUT_IRQ_EN
    // Interrupt mask and level interrupt, lagging its condition by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_irq_mask <= writedata[IRQM_BIT];
            r_irq <= r_irq_mask && (w_empty || r_overflow);
        end
    end

    assign irq = r_irq;
`endif

endmodule

// File: tb/tb_testeio_memout_fifo.sv
// Self-checking bench for testeio_memout_fifo: directed register-map
// scenarios followed by randomized bus traffic, checked against a queue
// model. Define TESTEIO_MEMOUT_IRQ_EN to also check irq.
module tb_testeio_memout_fifo;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic [1:0]  address    = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = '0;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        out_valid;
    logic        out_ack    = 1'b0;
`ifdef TESTEIO_MEMOUT_IRQ_EN
    logic        irq;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0]  q[$];
    bit          m_en   = 1'b1;
    bit          m_ovf  = 1'b0;
    bit          m_mask = 1'b0;
    bit          m_irq  = 1'b0;
    logic [31:0] m_rd   = '0;

    testeio_memout_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .out_valid  (out_valid),
        .out_ack    (out_ack)
`ifdef TESTEIO_MEMOUT_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] addr);
        logic [31:0] v;
        v = '0;
        case (addr)
            2'd0: v = (q.size() > 0) ? {24'd0, q[0]} : 32'd0;
            2'd1: v = (q.size() == DEPTH ? 32'h1 : 32'h0)
                    | (q.size() == 0 ? 32'h2 : 32'h0)
                    | (m_ovf ? 32'h4 : 32'h0)
                    | (32'(q.size()) << 8);
            2'd2: v = (m_en ? 32'h1 : 32'h0) | (m_mask ? 32'h4 : 32'h0);
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, "/valid"}, {31'd0, out_valid}, {31'd0, (m_en && q.size() > 0)});
        check_eq({tag, "/port"}, {24'd0, out_port}, (q.size() > 0) ? {24'd0, q[0]} : 32'd0);
        check_eq({tag, "/rdata"}, readdata, m_rd);
`ifdef TESTEIO_MEMOUT_IRQ_EN
        check_eq({tag, "/irq"}, {31'd0, irq}, {31'd0, m_irq});
`endif
    endtask

    // One bus cycle: drive inputs, advance one edge, update the model, compare.
    task automatic bus_cycle(input string tag, input bit cs, input bit wn,
                             input logic [1:0] addr, input logic [31:0] wd, input bit ack);
        bit          wr;
        bit          pop;
        bit          push;
        bit          flush;
        int          sz;
        logic [31:0] rd_exp;
        bit          irq_nxt;
        chipselect = cs;
        write_n    = wn;
        address    = addr;
        writedata  = wd;
        out_ack    = ack;
        wr      = cs && !wn;
        sz      = q.size();
        pop     = m_en && (sz > 0) && ack;
        push    = wr && (addr == 2'd0);
        flush   = wr && (addr == 2'd2) && wd[1];
        rd_exp  = model_read(addr);
        irq_nxt = m_mask && ((sz == 0) || m_ovf);
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                if (sz < DEPTH || pop) q.push_back(wd[7:0]);
                else                   m_ovf = 1'b1;
            end
        end
        if (wr && addr == 2'd1 && wd[2]) m_ovf = 1'b0;
        if (wr && addr == 2'd2) begin
            m_en = wd[0];
`ifdef TESTEIO_MEMOUT_IRQ_EN
            m_mask = wd[2];
`endif
        end
        m_rd  = rd_exp;
        m_irq = irq_nxt;
        check_outputs(tag);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data, input bit ack = 1'b0);
        bus_cycle("wr", 1'b1, 1'b0, addr, data, ack);
    endtask

    task automatic rd(input logic [1:0] addr, input bit ack = 1'b0);
        bus_cycle("rd", 1'b0, 1'b1, addr, 32'd0, ack);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_seq [4];

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rdata", readdata, 32'd0);
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_port", {24'd0, out_port}, 32'd0);
`ifdef TESTEIO_MEMOUT_IRQ_EN
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
`endif
        reset_n = 1'b1;

        rd(2'd0); check_eq("rst_addr0", readdata, 32'h0);
        rd(2'd1); check_eq("rst_addr1", readdata, 32'h2);
        rd(2'd2); check_eq("rst_addr2", readdata, 32'h1);
        rd(2'd3); check_eq("rst_addr3", readdata, 32'h0);

        // Single byte through the handshake
        wr(2'd0, 32'hA5);
        check_eq("a5_valid", {31'd0, out_valid}, 32'd1);
        check_eq("a5_port", {24'd0, out_port}, 32'hA5);
        rd(2'd1); check_eq("a5_count", readdata, 32'h100);
        rd(2'd3, 1'b1);
        check_eq("a5_popped", {31'd0, out_valid}, 32'd0);
        rd(2'd1); check_eq("a5_empty", readdata, 32'h2);

        // Overflow on a full FIFO with no pop
        for (int i = 1; i <= 5; i++) wr(2'd0, 32'(i * 8'h11));
        rd(2'd1); check_eq("ovf_status", readdata, 32'h405);
        exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            check_eq("ovf_drain", {24'd0, out_port}, {24'd0, exp_seq[i]});
            rd(2'd3, 1'b1);
        end
        check_eq("ovf_drained", {31'd0, out_valid}, 32'd0);
        wr(2'd1, 32'h4);
        rd(2'd1); check_eq("ovf_clear", readdata, 32'h2);

        // Push into a full FIFO together with a pop
        for (int i = 1; i <= 4; i++) wr(2'd0, 32'(i * 8'h11));
        wr(2'd0, 32'h66, 1'b1);
        rd(2'd1); check_eq("full_pushpop", readdata, 32'h401);
        exp_seq = '{8'h22, 8'h33, 8'h44, 8'h66};
        for (int i = 0; i < 4; i++) begin
            check_eq("full_drain", {24'd0, out_port}, {24'd0, exp_seq[i]});
            rd(2'd3, 1'b1);
        end

        // Flush followed by a push
        for (int i = 1; i <= 3; i++) wr(2'd0, 32'(i));
        wr(2'd2, 32'h2);
        rd(2'd1); check_eq("flush_empty", readdata, 32'h2);
        wr(2'd0, 32'h77);
        rd(2'd1); check_eq("flush_one", readdata, 32'h100);
        wr(2'd2, 32'h1);
        check_eq("flush_head", {24'd0, out_port}, 32'h77);
        rd(2'd3, 1'b1);

        // Enable gating, with irq_mask set when the feature is present
        wr(2'd2, 32'h5);
        wr(2'd0, 32'hAA);
        wr(2'd0, 32'hBB);
        wr(2'd2, 32'h4);
        rd(2'd3, 1'b1);
        rd(2'd3, 1'b1);
        check_eq("dis_valid", {31'd0, out_valid}, 32'd0);
        rd(2'd1); check_eq("dis_hold", readdata, 32'h200);
        wr(2'd2, 32'h5);
        check_eq("en_first", {24'd0, out_port}, 32'hAA);
        rd(2'd3, 1'b1);
        check_eq("en_second", {24'd0, out_port}, 32'hBB);
        rd(2'd3, 1'b1);
        rd(2'd3);
`ifdef TESTEIO_MEMOUT_IRQ_EN
        check_eq("irq_empty", {31'd0, irq}, 32'd1);
`endif

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            int unsigned r;
            logic [1:0]  a;
            logic [31:0] d;
            r = $urandom_range(0, 99);
            a = (r < 60) ? 2'd0 : (r < 75) ? 2'd1 : (r < 90) ? 2'd2 : 2'd3;
            d = $urandom;
            if (a == 2'd2) begin
                d[0] = ($urandom_range(0, 3) != 0);
                d[1] = ($urandom_range(0, 4) == 0);
            end
            bus_cycle("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                      a, d, bit'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of traffic
        wr(2'd2, 32'h1);
        wr(2'd0, 32'h5A);
        wr(2'd0, 32'h5B);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("arst_port", {24'd0, out_port}, 32'd0);
        check_eq("arst_rdata", readdata, 32'd0);
        q.delete();
        m_en = 1'b1; m_ovf = 1'b0; m_mask = 1'b0; m_irq = 1'b0; m_rd = '0;
        chipselect = 1'b0; write_n = 1'b1; out_ack = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd1); check_eq("arst_status", readdata, 32'h2);
        rd(2'd2); check_eq("arst_ctrl", readdata, 32'h1);

        chipselect = 1'b0;
        write_n    = 1'b1;
        out_ack    = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
